// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: FSM state encoding, rw and ack bit values.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_A_ACK,
    ST_PTR,
    ST_P_ACK,
    ST_WDATA,
    ST_D_ACK,
    ST_TX,
    ST_WAIT_STOP
  } i2c_tgt_state_t;

  localparam logic I2C_WR   = 1'b0;
  localparam logic I2C_RD   = 1'b1;
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronisers for SCL/SDA with registered edge and START/STOP flags.
module i2c_bus_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o
);

  logic [1:0] scl_q;
  logic [1:0] sda_q;
  logic       scl_hi;

  // START/STOP only count when SCL was high in both stages, so an SCL edge
  // landing in the same sample as an SDA edge wins and no condition is flagged.
  assign scl_hi = scl_q[0] & scl_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_q       <= 2'b11;
      sda_q       <= 2'b11;
      sda_o       <= 1'b1;
      scl_rise_o  <= 1'b0;
      scl_fall_o  <= 1'b0;
      start_det_o <= 1'b0;
      stop_det_o  <= 1'b0;
    end else begin
      scl_q       <= {scl_q[0], scl_i};
      sda_q       <= {sda_q[0], sda_i};
      sda_o       <= sda_q[0];
      scl_rise_o  <= scl_q[0] & ~scl_q[1];
      scl_fall_o  <= ~scl_q[0] & scl_q[1];
      start_det_o <= scl_hi & ~sda_q[0] & sda_q[1];
      stop_det_o  <= scl_hi & sda_q[0] & ~sda_q[1];
    end
  end

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target with an auto-incrementing pointer into a byte-wide register file.
// state        | meaning
// IDLE         | bus free, SDA released
// ADDR         | shifting address + rw byte
// A_ACK        | acking our address
// PTR          | shifting register pointer byte
// P_ACK        | acking a valid pointer
// WDATA        | shifting a write data byte
// D_ACK        | acking a committed data byte
// TX           | transmitting regs[ptr], then sampling master ack
// WAIT_STOP    | ignoring bus until START/STOP
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDRESS  = 7'b1100100,
  parameter int         NUM_REGS = 4,
  parameter int         PTR_W    = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SCL,
  inout  wire                   SDA,
  output logic [NUM_REGS*8-1:0] regs,
  output logic                  wr_strobe,
  output logic [PTR_W-1:0]      wr_index,
  output logic                  rx_done,
  output logic                  busy
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk         (clk),
    .reset       (reset),
    .scl_i       (SCL),
    .sda_i       (SDA),
    .sda_o       (sda_s),
    .scl_rise_o  (scl_rise),
    .scl_fall_o  (scl_fall),
    .start_det_o (start_det),
    .stop_det_o  (stop_det)
  );

  i2c_tgt_state_t   state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc;
  logic             drive_q, drive_d;
  logic             rw_q, rw_d;
  logic             wrote_q, wrote_d;
  logic             wr_strobe_q, rx_done_q, rx_done_d;
  logic [PTR_W-1:0] wr_index_q;
  logic [7:0]       regs_q [NUM_REGS];
  logic [7:0]       rx_byte;
  logic             recv_st, byte_end, commit;

  assign rx_byte  = {shift_q[6:0], sda_s};
  assign recv_st  = (state_q == ST_ADDR) || (state_q == ST_PTR) || (state_q == ST_WDATA);
  assign byte_end = scl_rise && recv_st && (cnt_q == 4'd7);
  assign ptr_inc  = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + PTR_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    drive_d   = drive_q;
    rw_d      = rw_q;
    wrote_d   = wrote_q;
    rx_done_d = 1'b0;
    commit    = 1'b0;
    if (stop_det) begin
      state_d   = ST_IDLE;
      drive_d   = 1'b0;
      cnt_d     = '0;
      rx_done_d = wrote_q;
      wrote_d   = 1'b0;
    end else if (start_det) begin
      state_d = ST_ADDR;
      drive_d = 1'b0;
      cnt_d   = '0;
    end else begin
      if (scl_rise && recv_st) begin
        shift_d = rx_byte;
        cnt_d   = byte_end ? 4'd0 : cnt_q + 4'd1;
      end
      unique case (state_q)
        ST_ADDR: if (byte_end) begin
          rw_d    = rx_byte[0];
          state_d = (rx_byte[7:1] == ADDRESS) ? ST_A_ACK : ST_WAIT_STOP;
        end
        ST_PTR: if (byte_end) begin
          if ({1'b0, rx_byte} < 9'(NUM_REGS)) begin
            ptr_d   = rx_byte[PTR_W-1:0];
            state_d = ST_P_ACK;
          end else begin
            state_d = ST_WAIT_STOP;
          end
        end
        ST_WDATA: if (byte_end) begin
          commit  = 1'b1;
          wrote_d = 1'b1;
          state_d = ST_D_ACK;
        end
        // First fall (end of bit 8) asserts the ack, second fall releases it.
        ST_A_ACK, ST_P_ACK, ST_D_ACK: if (scl_fall) begin
          drive_d = ~drive_q;
          if (drive_q) begin
            if (state_q == ST_D_ACK) begin
              ptr_d   = ptr_inc;
              state_d = ST_WDATA;
            end else if (state_q == ST_P_ACK) begin
              state_d = ST_WDATA;
            end else if (rw_q == I2C_RD) begin
              state_d = ST_TX;
              cnt_d   = '0;
              shift_d = regs_q[ptr_q];
              drive_d = ~regs_q[ptr_q][7];
            end else begin
              state_d = ST_PTR;
            end
          end
        end
        ST_TX: begin
          if (scl_rise) begin
            if (cnt_q == 4'd8) begin
              cnt_d = '0;
              if (sda_s == I2C_ACK) ptr_d = ptr_inc;
              else                  state_d = ST_WAIT_STOP;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              shift_d = regs_q[ptr_q];
              drive_d = ~regs_q[ptr_q][7];
            end else if (cnt_q == 4'd8) begin
              drive_d = 1'b0;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              drive_d = ~shift_q[6];
            end
          end
        end
        ST_IDLE, ST_WAIT_STOP: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      drive_q     <= 1'b0;
      rw_q        <= I2C_WR;
      wrote_q     <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_index_q  <= '0;
      rx_done_q   <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      drive_q     <= drive_d;
      rw_q        <= rw_d;
      wrote_q     <= wrote_d;
      wr_strobe_q <= commit;
      rx_done_q   <= rx_done_d;
      if (commit) begin
        regs_q[ptr_q] <= rx_byte;
        wr_index_q    <= ptr_q;
      end
    end
  end

  assign SDA       = drive_q ? 1'b0 : 1'bz;
  assign wr_strobe = wr_strobe_q;
  assign wr_index  = wr_index_q;
  assign rx_done   = rx_done_q;
  assign busy      = (state_q != ST_IDLE);

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign regs[8*k +: 8] = regs_q[k];
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: bit-banged I2C master with hand-computed expectations.
module tb_i2c_slave_regfile;

  localparam int Q = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        scl;
  logic        sda_m;
  wire         SDA;
  logic [31:0] regs;
  logic        wr_strobe;
  logic [1:0]  wr_index;
  logic        rx_done;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;
  int n_strobe = 0;
  int n_rx = 0;
  int idx_log[$];

  always #5 clk = ~clk;

  pullup (SDA);
  assign SDA = sda_m ? 1'bz : 1'b0;

  i2c_slave_regfile #(.ADDRESS(7'b1100100), .NUM_REGS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .SCL       (scl),
    .SDA       (SDA),
    .regs      (regs),
    .wr_strobe (wr_strobe),
    .wr_index  (wr_index),
    .rx_done   (rx_done),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (wr_strobe) begin
      n_strobe++;
      idx_log.push_back(int'(wr_index));
    end
    if (rx_done) n_rx++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int idx_at(input int i);
    return (i < idx_log.size()) ? idx_log[i] : -1;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    sda_m = b;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    s = SDA;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    sda_m = 1'b0;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    sda_m = 1'b1;
    wait_clk(2 * Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
    bit_xfer(1'b1, ack);
  endtask

  task automatic read_byte(input logic ack_in, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      d[i] = s;
    end
    bit_xfer(ack_in, s);
  endtask

  typedef struct {
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    int         idx0;
    int         idx1;
  } wr_vec_t;

  wr_vec_t vecs[2];

  initial begin
    logic       a;
    logic       s;
    logic [7:0] d;
    int         s0;
    int         r0;

    vecs[0] = '{ptr: 8'h01, d0: 8'hAB, d1: 8'hCD, idx0: 1, idx1: 2};
    vecs[1] = '{ptr: 8'h03, d0: 8'h11, d1: 8'h22, idx0: 3, idx1: 0};

    reset = 1'b1;
    scl   = 1'b1;
    sda_m = 1'b1;
    wait_clk(4);
    check("rst_sda", 32'(SDA), 32'd1);
    check("rst_regs", regs, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobe", 32'(wr_strobe), 32'd0);
    check("rst_rx_done", 32'(rx_done), 32'd0);
    check("rst_wr_index", 32'(wr_index), 32'd0);
    reset = 1'b0;
    wait_clk(4);

    for (int v = 0; v < 2; v++) begin
      s0 = n_strobe;
      r0 = n_rx;
      i2c_start();
      check("wr_busy", 32'(busy), 32'd1);
      write_byte(8'hC8, a);
      check("wr_addr_ack", 32'(a), 32'd0);
      write_byte(vecs[v].ptr, a);
      check("wr_ptr_ack", 32'(a), 32'd0);
      write_byte(vecs[v].d0, a);
      check("wr_d0_ack", 32'(a), 32'd0);
      write_byte(vecs[v].d1, a);
      check("wr_d1_ack", 32'(a), 32'd0);
      i2c_stop();
      check("wr_strobes", 32'(n_strobe - s0), 32'd2);
      check("wr_idx0", 32'(idx_at(s0)), 32'(vecs[v].idx0));
      check("wr_idx1", 32'(idx_at(s0 + 1)), 32'(vecs[v].idx1));
      check("wr_reg0", 32'(regs[8*vecs[v].idx0 +: 8]), 32'(vecs[v].d0));
      check("wr_reg1", 32'(regs[8*vecs[v].idx1 +: 8]), 32'(vecs[v].d1));
      check("wr_rx_done", 32'(n_rx - r0), 32'd1);
      check("wr_idle", 32'(busy), 32'd0);
    end
    check("regs_after_writes", regs, 32'h11CDAB22);

    // Pointer write, repeated START, read two bytes (ACK then NACK).
    s0 = n_strobe;
    r0 = n_rx;
    i2c_start();
    write_byte(8'hC8, a);
    check("rd_waddr_ack", 32'(a), 32'd0);
    write_byte(8'h02, a);
    check("rd_ptr_ack", 32'(a), 32'd0);
    i2c_start();
    write_byte(8'hC9, a);
    check("rd_raddr_ack", 32'(a), 32'd0);
    read_byte(1'b0, d);
    check("rd_byte0", 32'(d), 32'hCD);
    read_byte(1'b1, d);
    check("rd_byte1", 32'(d), 32'h11);
    i2c_stop();
    check("rd_no_strobe", 32'(n_strobe - s0), 32'd0);
    check("rd_no_rx_done", 32'(n_rx - r0), 32'd0);
    check("rd_idle", 32'(busy), 32'd0);

    // Foreign address is NACKed and ignored.
    s0 = n_strobe;
    i2c_start();
    write_byte(8'hA0, a);
    check("wa_nack", 32'(a), 32'd1);
    write_byte(8'h01, a);
    check("wa_byte_nack", 32'(a), 32'd1);
    i2c_stop();
    check("wa_regs", regs, 32'h11CDAB22);
    check("wa_no_strobe", 32'(n_strobe - s0), 32'd0);
    check("wa_idle", 32'(busy), 32'd0);

    // Out-of-range pointer is NACKed, following data ignored.
    s0 = n_strobe;
    r0 = n_rx;
    i2c_start();
    write_byte(8'hC8, a);
    check("bp_addr_ack", 32'(a), 32'd0);
    write_byte(8'h07, a);
    check("bp_ptr_nack", 32'(a), 32'd1);
    write_byte(8'h55, a);
    check("bp_data_nack", 32'(a), 32'd1);
    i2c_stop();
    check("bp_no_strobe", 32'(n_strobe - s0), 32'd0);
    check("bp_no_rx_done", 32'(n_rx - r0), 32'd0);
    check("bp_regs", regs, 32'h11CDAB22);

    // STOP after 4 data bits discards the partial byte.
    s0 = n_strobe;
    r0 = n_rx;
    i2c_start();
    write_byte(8'hC8, a);
    write_byte(8'h00, a);
    check("ab_ptr_ack", 32'(a), 32'd0);
    bit_xfer(1'b1, s);
    bit_xfer(1'b0, s);
    bit_xfer(1'b1, s);
    bit_xfer(1'b0, s);
    i2c_stop();
    check("ab_no_strobe", 32'(n_strobe - s0), 32'd0);
    check("ab_no_rx_done", 32'(n_rx - r0), 32'd0);
    check("ab_regs", regs, 32'h11CDAB22);

    // Read regs[0]=0x22 (bits 0,0,...), reset while target drives a 0 bit.
    i2c_start();
    write_byte(8'hC9, a);
    check("rr_addr_ack", 32'(a), 32'd0);
    bit_xfer(1'b1, s);
    check("rr_bit7", 32'(s), 32'd0);
    sda_m = 1'b1;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    check("rr_bit6_driven", 32'(SDA), 32'd0);
    reset = 1'b1;
    #1;
    check("rr_rst_sda", 32'(SDA), 32'd1);
    check("rr_rst_regs", regs, 32'h0);
    check("rr_rst_busy", 32'(busy), 32'd0);
    wait_clk(3);
    reset = 1'b0;
    wait_clk(4 * Q);
    check("rr_post_sda", 32'(SDA), 32'd1);
    check("rr_post_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
